// File: rtl/demux_stream_router_pkg.sv
// Shared constants and helpers for the stream router.
// Includes the channel bit-offset function and the saturating counter increment.
package demux_pkg;

    localparam int MAX_OUT = 32;

    function automatic int chan_slice(input int k, input int data_w);
        return k * data_w;
    endfunction

    // Holds at 2^w-1 instead of wrapping; callers size-cast the result back to w bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/demux_stream_router_out_hold_reg.sv
// Single-entry valid/ready holding register for one output channel.
// Latency: 1 cycle from load to valid; drain and reload in one cycle keeps full rate.
// Backpressure: contents frozen while valid & !ready; the upstream must not load then.
module out_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_router.sv
// Routes one valid/ready stream to a selected channel or to all channels; bad selects are dropped.
// Latency: 1 cycle input to out_valid; drop_cnt/sel_err update 1 cycle after the dropped beat.
// Backpressure: in_ready follows the target channel(s); broadcast waits until every channel can accept.
module demux_stream_router
    import demux_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_OUT = 8,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      sel_err
);

    logic [NUM_OUT-1:0] can_accept;
    logic [NUM_OUT-1:0] load;
    logic               in_range;
    logic               fire;
    logic               drop;

    assign can_accept = ~out_valid | out_ready;
    assign in_range   = (32'(in_sel) < 32'(NUM_OUT));
    assign fire       = in_valid & in_ready;
    assign drop       = fire & ~in_bcast & ~in_range;

    // Out-of-range unicast is always accepted so a bad select can never stall the producer.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &can_accept;
        end else if (in_range) begin
            in_ready = can_accept[in_sel];
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        assign load[k] = fire & (in_bcast | (in_range & (in_sel == SEL_W'(k))));

        out_hold_reg #(
            .DATA_W (DATA_W)
        ) u_hold (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[chan_slice(k, DATA_W) +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_err <= drop;
            if (drop) begin
                drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed + random bench for demux_stream_router: an 8-channel default instance checked
// against a queue-based reference model, and a 6-channel/2-bit-counter instance for drops.
module tb_demux_stream_router;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_bcast, in_ready;
    logic [2:0]  in_sel;
    logic [7:0]  in_data;
    logic [7:0]  out_valid, out_ready;
    logic [63:0] out_data;
    logic [15:0] drop_cnt;
    logic        sel_err;

    logic        d_valid, d_bcast, d_ready;
    logic [2:0]  d_sel;
    logic [7:0]  d_data;
    logic [5:0]  d_ovalid, d_oready;
    logic [47:0] d_odata;
    logic [1:0]  d_drop;
    logic        d_err;

    int tests = 0;
    int fails = 0;

    // Reference model: each channel is a FIFO of delivered-but-unconsumed beats, plus
    // the last value ever loaded (what out_data shows once the channel drains).
    logic [7:0] mq[8][$];
    logic [7:0] mlast[8];
    int         dexp;

    always #5 clk = ~clk;

    demux_stream_router u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .sel_err   (sel_err)
    );

    demux_stream_router #(
        .NUM_OUT (6),
        .CNT_W   (2)
    ) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_valid),
        .in_ready  (d_ready),
        .in_data   (d_data),
        .in_sel    (d_sel),
        .in_bcast  (d_bcast),
        .out_valid (d_ovalid),
        .out_ready (d_oready),
        .out_data  (d_odata),
        .drop_cnt  (d_drop),
        .sel_err   (d_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_can(input int k);
        return (mq[k].size() == 0) || out_ready[k];
    endfunction

    function automatic logic m_ready();
        logic r;
        if (in_bcast) begin
            r = 1'b1;
            for (int k = 0; k < 8; k++) r = r & m_can(k);
        end else begin
            r = m_can(int'(in_sel));
        end
        return r;
    endfunction

    function automatic logic [7:0] m_vld();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic [63:0] m_dat();
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = mlast[k];
        return d;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 8; k++) begin
            mq[k].delete();
            mlast[k] = 8'h00;
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic step();
        logic rdy;
        logic fire;
        #1;
        rdy = m_ready();
        chk("in_ready", 64'(in_ready), 64'(rdy));
        fire = in_valid & rdy;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
        end
        if (fire) begin
            for (int k = 0; k < 8; k++) begin
                if (in_bcast || int'(in_sel) == k) begin
                    mq[k].push_back(in_data);
                    mlast[k] = in_data;
                end
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_vld()));
        chk("out_data", out_data, m_dat());
        chk("drop_cnt_main", 64'(drop_cnt), 64'd0);
        chk("sel_err_main", 64'(sel_err), 64'd0);
    endtask

    task automatic send(input logic v, input logic [2:0] s, input logic [7:0] d, input logic b);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_bcast = b;
        step();
    endtask

    // Drop-path instance: all consumers ready, so every in-range beat lands and drains next cycle.
    task automatic d_step(input logic v, input logic [2:0] s, input logic [7:0] d);
        bit is_drop;
        d_valid = v;
        d_sel   = s;
        d_data  = d;
        is_drop = v && (s >= 3'd6);
        #1;
        chk("d_in_ready", 64'(d_ready), 64'd1);
        @(posedge clk);
        if (is_drop) dexp = (dexp < 3) ? dexp + 1 : 3;
        #1;
        chk("d_out_valid", 64'(d_ovalid), (v && s < 3'd6) ? (64'd1 << s) : 64'd0);
        if (v && s < 3'd6) chk("d_out_data", 64'(d_odata[s*8 +: 8]), 64'(d));
        chk("d_drop_cnt", 64'(d_drop), 64'(dexp));
        chk("d_sel_err", 64'(d_err), 64'(is_drop));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        in_bcast  = 1'b0;
        out_ready = 8'hFF;
        d_valid   = 1'b0;
        d_sel     = '0;
        d_data    = '0;
        d_bcast   = 1'b0;
        d_oready  = 6'h3F;
        dexp      = 0;
        m_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_sel_err", 64'(sel_err), 64'd0);
        chk("rst_d_drop", 64'(d_drop), 64'd0);
        rst_n = 1'b1;

        // Sweep every channel with all consumers ready.
        for (int s = 0; s < 8; s++) begin
            send(1'b1, 3'(s), 8'hA5, 1'b0);
            chk("sweep_onehot", 64'(out_valid), 64'd1 << s);
            chk("sweep_data", 64'(out_data[s*8 +: 8]), 64'hA5);
        end
        send(1'b0, 3'd0, 8'h00, 1'b0);

        // Back-pressure on channel 3 while channel 5 keeps flowing.
        out_ready = 8'hF7;
        send(1'b1, 3'd3, 8'h11, 1'b0);
        send(1'b1, 3'd3, 8'h22, 1'b0);
        chk("bp_blocked", 64'(in_ready), 64'd0);
        chk("bp_hold", 64'(out_data[31:24]), 64'h11);
        send(1'b1, 3'd5, 8'h33, 1'b0);
        chk("bp_pass5", 64'(out_data[47:40]), 64'h33);
        chk("bp_still_hold", 64'(out_data[31:24]), 64'h11);
        out_ready = 8'hFF;
        send(1'b1, 3'd3, 8'h22, 1'b0);
        chk("bp_second", 64'(out_data[31:24]), 64'h22);
        send(1'b0, 3'd0, 8'h00, 1'b0);

        // Broadcast stalls behind a full channel, then goes everywhere at once.
        out_ready = 8'hBF;
        send(1'b1, 3'd6, 8'h66, 1'b0);
        send(1'b1, 3'd0, 8'h5A, 1'b1);
        chk("bc_blocked", 64'(out_valid), 64'h40);
        out_ready = 8'hFF;
        send(1'b1, 3'd0, 8'h5A, 1'b1);
        chk("bc_all_valid", 64'(out_valid), 64'hFF);
        chk("bc_all_data", out_data, {8{8'h5A}});
        send(1'b0, 3'd0, 8'h00, 1'b0);

        // Back-to-back beats on one channel with no bubbles.
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 3'd2, 8'(i), 1'b0);
            chk("tput_valid", 64'(out_valid[2]), 64'd1);
            chk("tput_data", 64'(out_data[23:16]), 64'(i));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            out_ready = 8'($urandom);
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between edges, then normal latency after release.
        out_ready = 8'hEF;
        send(1'b1, 3'd4, 8'h44, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 8'hFF;
        send(1'b1, 3'd1, 8'h77, 1'b0);
        chk("arst_first_valid", 64'(out_valid), 64'h02);
        chk("arst_first_data", 64'(out_data[15:8]), 64'h77);
        in_valid = 1'b0;

        // Drop path on the 6-channel instance with a 2-bit saturating counter.
        d_step(1'b1, 3'd6, 8'hC1);
        d_step(1'b0, 3'd0, 8'h00);
        d_step(1'b1, 3'd7, 8'hC2);
        d_step(1'b1, 3'd2, 8'hAB);
        for (int i = 0; i < 4; i++) begin
            d_step(1'b1, 3'($urandom_range(6, 7)), 8'($urandom));
        end
        chk("d_saturated", 64'(d_drop), 64'd3);
        d_step(1'b0, 3'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Parametrised, registered successor to the combinational 1-to-8 demux.
- Routes one valid/ready input stream to one of NUM_OUT output channels, or to all channels in broadcast mode.
- Each output has a one-entry holding register, so back-pressure on one channel does not corrupt the others.
- Out-of-range selects are dropped and counted.
- Sits between a single producer and NUM_OUT independent consumers in the datapath.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_OUT, 8, number of output channels (2..32; need not be a power of two).
- SEL_W, $clog2(NUM_OUT), select width. Derived localparam, not overridable.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  input beat accepted this cycle when in_valid & in_ready.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index (ignored when in_bcast=1).
- in_bcast  in  1  1 = deliver beat to every channel.
- out_valid  out  NUM_OUT  per-channel holding register full.
- out_ready  in  NUM_OUT  per-channel consumer ready.
- out_data  out  NUM_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of dropped beats (out-of-range sel).
- sel_err  out  1  one-cycle pulse when a beat is dropped.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, drop_cnt=0, sel_err=0.
- Channel k "can accept" = !out_valid[k] | out_ready[k].
- in_ready is combinational from in_sel, in_bcast, out_valid and out_ready:
  - Unicast, in_sel < NUM_OUT: can_accept[in_sel].
  - Broadcast: AND of can_accept over all channels.
  - Unicast, in_sel >= NUM_OUT: 1 (drop path).
- in_ready does not depend on in_valid.
- Unicast accept with in-range sel: at the next edge out_valid[sel]=1 and out_data[sel]=in_data. Latency is 1 cycle. Other channels are unaffected.
- Broadcast accept: every channel loads in_data and sets out_valid at the same edge. It is all-or-nothing; no partial delivery.
- Drop (accepted with in_sel >= NUM_OUT, unicast):
  - No channel is written.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - sel_err=1 for the following cycle only.
- Output handshake per channel:
  - out_valid & out_ready with no new load clears out_valid the next cycle.
  - Drain and load in the same cycle: out_valid stays 1 and out_data takes the new beat. This gives full throughput, one beat per cycle per channel.
- Stability: while out_valid[k] & !out_ready[k], out_data[k] and out_valid[k] hold constant.
- No beat is lost or duplicated except documented drops.
- Ordering is FIFO per channel; there is no cross-channel ordering guarantee.
- Reset mid-operation: all held beats are discarded immediately (async); drop_cnt clears.
- in_valid=0: no state change apart from output drains.

Decomposition:
- Shared package demux_pkg holds:
  - the max-channel constant MAX_OUT=32;
  - a function chan_slice(k) returning the bit offset k*DATA_W;
  - the saturating-increment helper used by drop_cnt.
- One sub-module, out_hold_reg: the single-entry valid/ready holding register with inputs load, load_data, ready and outputs valid, data.
- The top instantiates it NUM_OUT times via generate and adds the select/ready/drop logic.

Test Plan:
- Sweep, out_ready all 1: in_bcast=0, in_data=8'hA5, in_sel=0..7 one per cycle, in_valid=1. Expect in_ready=1 every cycle, out_valid one-hot=(1<<sel) one cycle later, out_data[sel]=A5, all other channels unchanged.
- Back-pressure: out_ready[3]=0, send two beats to sel=3 (8'h11 then 8'h22). Expect the first held with out_data[3]=11, in_ready=0 on the second. Meanwhile a beat 8'h33 to sel=5 passes. Raising out_ready[3] yields 11 then 22, in order.
- Broadcast: in_bcast=1, in_data=8'h5A with out_ready[6]=0 and channel 6 full. Expect in_ready=0 and no channel loaded. Release out_ready[6]: all 8 channels show 5A one cycle after accept.
- Drop with NUM_OUT=6 (SEL_W=3): in_sel=6 then 7. Expect in_ready=1, no out_valid change, drop_cnt 0→1→2, a sel_err pulse after each. With CNT_W=2, four more drops saturate drop_cnt at 3.
- Full throughput: sel=2, out_ready[2]=1, 16 back-to-back beats 0..15. Expect out_valid[2] continuously 1 after the first edge and out_data[2] sequence 0..15 with no bubbles.
- Async reset: assert rst_n=0 mid-stream between clock edges. Expect out_valid=0, out_data=0, drop_cnt=0 immediately, with no clock needed. After release the first beat has normal 1-cycle latency.
